alu_wb_stage: RTL and testbench
===============================

Name: alu_wb_stage

Overview:
- Writeback stage directly downstream of the 4-bit ALU.
- Each accepted ALU result is committed to a 4-entry x 4-bit register file and to a Z/C/S flag register.
- The same result is pushed into a 2-entry result FIFO, drained by a valid/ready consumer.
- Register-file read ports supply the ALU A/B operands, with same-cycle write bypass.

Parameters:
- NREG, 4: register-file entries; address width is 2 bits, fixed for NREG=4.
- FIFO_DEPTH, 2: result FIFO entries; only 2 is supported.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result presented this cycle
- in_ready  out  1  stage can accept the ALU result
- R  in  4  ALU result
- zero  in  1  ALU zero flag
- carry  in  1  ALU carry; meaningful only when arit=1
- sign  in  1  ALU sign; meaningful only when arit=1
- arit  in  1  ALU arithmetic-mode indicator for this result
- wr_en  in  1  write R to the register file on accept
- wr_addr  in  2  destination register
- rd_addr_a  in  2  operand-A read address
- rd_addr_b  in  2  operand-B read address
- rd_a  out  4  operand A (combinational, bypassed)
- rd_b  out  4  operand B (combinational, bypassed)
- flag_z  out  1  committed zero flag
- flag_c  out  1  committed carry flag
- flag_s  out  1  committed sign flag
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts FIFO head
- out_data  out  9  FIFO head: {wr_addr[1:0], s, c, z, R[3:0]}

Behaviour:
- Reset (reset_n=0, asynchronous): all registers = 4'b0000; flag_z/c/s = 0; FIFO count = 0; out_valid = 0; out_data = 0.
- Reset asserted mid-operation discards FIFO contents and pending data immediately.
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count < 2) | out_ready. When the FIFO is full, a push is allowed only in a cycle that also pops.
- On accept:
  - if wr_en, reg[wr_addr] <= R;
  - flag_z <= zero;
  - if arit=1: flag_c <= carry and flag_s <= sign;
  - if arit=0: flag_c and flag_s hold. ALU C/S are undefined in logic mode and must never be sampled.
- FIFO push data uses the post-update flag values: s = arit ? sign : flag_s; c = arit ? carry : flag_c; z = zero.
- The push happens on every accept, regardless of wr_en.
- FIFO ordering:
  - strict FIFO order;
  - out_data is the registered head entry;
  - latency from accept to out_valid is 1 cycle when the FIFO is empty;
  - simultaneous push and pop keeps count unchanged; a push+pop on a 1-entry FIFO presents the new entry next cycle.
- Empty FIFO: out_valid = 0 and out_data holds its last value; pop is ignored.
- count never exceeds 2 and never goes below 0.
- Read ports (combinational):
  - rd_a = (accept & wr_en & wr_addr==rd_addr_a) ? R : reg[rd_addr_a]; rd_b likewise.
  - Bypass applies only on an actual accept; in_valid alone, without in_ready, gives no bypass.
- in_valid=0: no state change except FIFO pop.
- Outputs must never be driven X once reset has been applied, even if carry/sign inputs are X while arit=0.

Test Plan:
- Reset then idle:
  - reset_n=0 mid-stream with count=2 -> out_valid=0, flags=000, rd_a=rd_b=0 immediately;
  - after release, in_ready=1.
- Arithmetic commit: arit=1, R=4'b1001, carry=1, sign=1, zero=0, wr_en=1, wr_addr=2 -> next cycle reg2=9, flag_c=1, flag_s=1, flag_z=0, out_data=9'b10_1_1_0_1001, out_valid=1.
- Logic-mode flag hold: after the previous case, arit=0, R=0, zero=1, carry=X, sign=X -> flag_z=1, flag_c=1, flag_s=1 (held), FIFO entry c=1, s=1, no X on any output.
- Bypass: accept with wr_en=1, wr_addr=1, R=4'hA, rd_addr_a=1, rd_addr_b=1 in the same cycle -> rd_a=rd_b=4'hA that cycle; same stimulus with in_ready=0 -> old reg1 value.
- Backpressure:
  - out_ready=0, three consecutive in_valid results 3,5,7 -> 3 and 5 accepted, in_ready=0 on the third;
  - then out_ready=1 -> 7 accepted in the pop cycle; outputs drained in order 3,5,7.
- Simultaneous push/pop with count=1: head=4, push 6 while popping -> count stays 1, next out_data R=6.

Source files
------------

// File: rtl/alu_wb_stage.sv
// -----------------------------------------------------------------------------
// alu_wb_stage
//
// Writeback stage that sits directly after the 4-bit ALU. Each accepted ALU
// result is:
//   * written to a 4 x 4-bit register file (when wr_en is set),
//   * committed to the Z/C/S flag register (C/S only for arithmetic results),
//   * pushed into a 2-entry result FIFO drained by a valid/ready consumer.
// The register-file read ports feed the ALU operands. Each port bypasses a
// write that is being accepted in the same cycle.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid / in_ready     ALU result handshake
//   R, zero, carry, sign    ALU result and flags (carry/sign valid only if arit)
//   arit                    result came from an arithmetic operation
//   wr_en, wr_addr          register-file write control
//   rd_addr_a/b, rd_a/b     combinational operand read ports with bypass
//   flag_z/c/s              committed flags
//   out_valid / out_ready   result FIFO handshake
//   out_data                FIFO head {wr_addr, s, c, z, R}
// -----------------------------------------------------------------------------
module alu_wb_stage #(
  parameter int NREG       = 4,  // address width is fixed at 2 bits
  parameter int FIFO_DEPTH = 2   // only a depth of 2 is supported
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] R,
  input  logic       zero,
  input  logic       carry,
  input  logic       sign,
  input  logic       arit,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [1:0] rd_addr_a,
  input  logic [1:0] rd_addr_b,
  output logic [3:0] rd_a,
  output logic [3:0] rd_b,
  output logic       flag_z,
  output logic       flag_c,
  output logic       flag_s,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] out_data
);

  logic [3:0] regs [NREG];
  logic [1:0] count;
  logic [8:0] head_q;
  logic [8:0] tail_q;

  logic       accept;
  logic       pop;
  logic       c_next;
  logic       s_next;
  logic [8:0] push_data;

  // A full FIFO can still take a result in a cycle where the consumer pops.
  assign in_ready  = (count < 2'(FIFO_DEPTH)) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = head_q;

  // The select is always known, so undefined ALU C/S in logic mode never
  // reach the flags, the FIFO or any output.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    c_next = flag_c;
    s_next = flag_s;
    if (arit) begin
      c_next = carry;
      s_next = sign;
    end
  end

  // FIFO entries carry the flag values as they will be after this commit.
  assign push_data = {wr_addr, s_next, c_next, zero, R};

  // Same-cycle bypass, only when the write is really being accepted.
  assign rd_a = (accept && wr_en && (wr_addr == rd_addr_a)) ? R : regs[rd_addr_a];
  assign rd_b = (accept && wr_en && (wr_addr == rd_addr_b)) ? R : regs[rd_addr_b];

  // Register file and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the register file is small and must read as zero after reset,
      // so it lives in flops with an explicit reset rather than in a RAM.
      for (int i = 0; i < NREG; i++) regs[i] <= 4'b0000;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_s <= 1'b0;
    end else if (accept) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (wr_en) regs[wr_addr] <= R;
      flag_z <= zero;
      flag_c <= c_next;
      flag_s <= s_next;
    end
  end

  // Two-entry result FIFO: head_q is the registered output entry, tail_q the
  // entry behind it. When the FIFO empties, head_q keeps its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      unique case ({accept, pop})
        2'b10: begin
          if (count == 2'd0) head_q <= push_data;
          else               tail_q <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head_q <= tail_q;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_wb_stage
//
// Self-checking bench for alu_wb_stage. A behavioural model (register array,
// flag variables and a queue for the result FIFO) predicts every output each
// cycle. Directed steps cover the key scenarios, then random traffic follows.
// -----------------------------------------------------------------------------
module tb_alu_wb_stage;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] R;
  logic       zero;
  logic       carry;
  logic       sign;
  logic       arit;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [1:0] rd_addr_a;
  logic [1:0] rd_addr_b;
  logic [3:0] rd_a;
  logic [3:0] rd_b;
  logic       flag_z;
  logic       flag_c;
  logic       flag_s;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] out_data;

  always #5 clk = ~clk;

  alu_wb_stage dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .zero      (zero),
    .carry     (carry),
    .sign      (sign),
    .arit      (arit),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_s    (flag_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // Reference model state.
  logic [3:0] m_regs [4];
  logic       m_z, m_c, m_s;
  logic [8:0] m_q[$];
  logic [8:0] m_head;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [8:0] observed,
                       input logic [8:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
    m_z = 1'b0; m_c = 1'b0; m_s = 1'b0;
    m_q.delete();
    m_head = 9'd0;
  endtask

  // One clock cycle: drive inputs, check all outputs against the model just
  // before the rising edge, then advance the model and the clock.
  task automatic step(input logic iv, input logic [3:0] r, input logic z,
                      input logic c, input logic s, input logic ar,
                      input logic we, input logic [1:0] wa,
                      input logic [1:0] ra, input logic [1:0] rb,
                      input logic ordy);
    logic       e_ready, e_acc, e_pop, nc, ns;
    logic [3:0] e_rda, e_rdb;
    in_valid = iv; R = r; zero = z; carry = c; sign = s; arit = ar;
    wr_en = we; wr_addr = wa; rd_addr_a = ra; rd_addr_b = rb; out_ready = ordy;
    #3;
    e_ready = (m_q.size() < 2) || ordy;
    e_acc   = iv && e_ready;
    e_pop   = (m_q.size() > 0) && ordy;
    e_rda   = (e_acc && we && wa == ra) ? r : m_regs[ra];
    e_rdb   = (e_acc && we && wa == rb) ? r : m_regs[rb];
    check("in_ready",  9'(in_ready),  9'(e_ready));
    check("rd_a",      9'(rd_a),      9'(e_rda));
    check("rd_b",      9'(rd_b),      9'(e_rdb));
    check("flags_zcs", 9'({flag_z, flag_c, flag_s}), 9'({m_z, m_c, m_s}));
    check("out_valid", 9'(out_valid), 9'(m_q.size() > 0));
    check("out_data",  out_data,      m_head);
    if (e_pop) void'(m_q.pop_front());
    if (e_acc) begin
      nc = ar ? c : m_c;
      ns = ar ? s : m_s;
      if (we) m_regs[wa] = r;
      m_z = z; m_c = nc; m_s = ns;
      m_q.push_back({wa, ns, nc, z, r});
    end
    if (m_q.size() > 0) m_head = m_q[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy, input logic [1:0] ra);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, ra, ra, ordy);
  endtask

  initial begin
    logic ar, iv, ordy;
    reset_n = 1'b0;
    in_valid = 1'b0; R = '0; zero = 1'b0; carry = 1'b0; sign = 1'b0;
    arit = 1'b0; wr_en = 1'b0; wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0;
    out_ready = 1'b0;
    model_reset();
    #12;
    check("rst_out_valid", 9'(out_valid), 9'd0);
    check("rst_out_data",  out_data,      9'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Arithmetic commit, then logic-mode commit with undefined C/S.
    step(1'b1, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2'd2, 2'd2, 2'd2, 1'b1);
    step(1'b1, 4'b0000, 1'b1, 1'bx, 1'bx, 1'b0, 1'b1, 2'd3, 2'd2, 2'd0, 1'b1);
    check("logic_mode_entry", out_data, 9'b11_1_1_1_0000);
    idle(1'b1, 2'd3);

    // Bypass on an accepted write to reg1.
    step(1'b1, 4'hA, 1'b0, 1'bx, 1'bx, 1'b0, 1'b1, 2'd1, 2'd1, 2'd1, 1'b1);
    idle(1'b1, 2'd1);

    // Backpressure: 3 and 5 accepted, 7 refused, and a refused write to reg1
    // must not bypass.
    step(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0);
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0);
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 1'b0);
    step(1'b1, 4'hB, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 2'd1, 2'd1, 1'b0);
    check("no_bypass_when_stalled", 9'(m_regs[1]), 9'h00A);
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 2'd1, 1'b1);
    idle(1'b1, 2'd0);
    idle(1'b1, 2'd0);
    idle(1'b1, 2'd0);

    // Push and pop together on a one-entry FIFO.
    step(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    step(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
    idle(1'b0, 2'd0);
    check("push_pop_head", 9'(m_head[3:0]), 9'd6);

    // Asynchronous reset with a full FIFO.
    step(1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd2, 1'b0);
    idle(1'b0, 2'd2);
    in_valid = 1'b0;
    rd_addr_a = 2'd2;
    rd_addr_b = 2'd0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out_valid", 9'(out_valid), 9'd0);
    check("async_rst_flags", 9'({flag_z, flag_c, flag_s}), 9'd0);
    check("async_rst_rd_a", 9'(rd_a), 9'd0);
    check("async_rst_rd_b", 9'(rd_b), 9'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1'b0, 2'd1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      ar   = 1'($urandom_range(0, 1));
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(iv, 4'($urandom), 1'($urandom), ar ? 1'($urandom) : 1'bx,
           ar ? 1'($urandom) : 1'bx, ar, 1'($urandom), 2'($urandom),
           2'($urandom), 2'($urandom), ordy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
